// File: rtl/speaker_envelope_pwm.sv
// ADSR envelope and master volume applied to the synchronized tone, producing an amplitude-modulated PWM speaker drive.
// Optional tremolo in SUSTAIN is enabled by defining SPK_ENV_TREMOLO_EN.
module speaker_envelope_pwm #(
    parameter int ATTACK_STEP_CYC  = 4096,
    parameter int DECAY_STEP_CYC   = 8192,
    parameter int RELEASE_STEP_CYC = 16384,
    parameter int SUSTAIN_LEVEL    = 160
`ifdef SPK_ENV_TREMOLO_EN
    ,
    parameter int TREM_STEP_CYC    = 65536
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    input  logic       note_start,
    input  logic       note_end,
    input  logic [3:0] volume,
    output logic       speaker,
    output logic [7:0] env_level,
    output logic       busy
);

    localparam int MAX_AD   = (ATTACK_STEP_CYC > DECAY_STEP_CYC) ? ATTACK_STEP_CYC : DECAY_STEP_CYC;
    localparam int MAX_STEP = (MAX_AD > RELEASE_STEP_CYC) ? MAX_AD : RELEASE_STEP_CYC;
    localparam int CW       = $clog2(MAX_STEP + 1);
    localparam logic [7:0] SUS_L  = 8'(SUSTAIN_LEVEL);
    localparam logic [7:0] SUS_P1 = 8'(SUSTAIN_LEVEL + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   step_q, step_d, step_lim_s;
    logic [7:0]      env_q, env_d;
    logic [7:0]      pwm_q, pwm_d;
    logic [1:0]      sync_q;
    logic            speaker_q, speaker_d;
    logic            busy_q, busy_d;
    logic            step_hit_s;
    logic [4:0]      vol_p1_s;
    logic [11:0]     prod_s;
    logic [7:0]      amp_s;
    logic [3:0]      unused_frac_s;

`ifdef SPK_ENV_TREMOLO_EN
    localparam int TW = $clog2(TREM_STEP_CYC + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [4:0]    tri_lvl_q, tri_lvl_d;
    logic          dir_up_q, dir_up_d;
    logic          trem_run_s;
    logic [7:0]    trem_env_s;

    // Triangle generator: runs only while SUSTAIN is held, otherwise parked at zero.
    always_comb begin
        tcnt_d     = '0;
        tri_lvl_d  = 5'd0;
        dir_up_d   = 1'b1;
        trem_run_s = (state_q == S_SUSTAIN) && !note_start && !note_end;
        if (trem_run_s) begin
            if (tcnt_q == TW'(TREM_STEP_CYC - 1)) begin
                tcnt_d = '0;
                if (dir_up_q) begin
                    tri_lvl_d = tri_lvl_q + 5'd1;
                    dir_up_d  = (tri_lvl_q != 5'd30);
                end else begin
                    tri_lvl_d = tri_lvl_q - 5'd1;
                    dir_up_d  = (tri_lvl_q == 5'd1);
                end
            end else begin
                tcnt_d    = tcnt_q + TW'(1);
                tri_lvl_d = tri_lvl_q;
                dir_up_d  = dir_up_q;
            end
        end else begin
            tcnt_d = '0;
        end
        if ({3'b000, tri_lvl_d} > SUS_L) begin
            trem_env_s = 8'd0;
        end else begin
            trem_env_s = SUS_L - {3'b000, tri_lvl_d};
        end
    end

    // Tremolo state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_q    <= '0;
            tri_lvl_q <= 5'd0;
            dir_up_q  <= 1'b1;
        end else begin
            tcnt_q    <= tcnt_d;
            tri_lvl_q <= tri_lvl_d;
            dir_up_q  <= dir_up_d;
        end
    end
`endif

    // Step period of the current state; SUSTAIN and IDLE never step.
    always_comb begin
        case (state_q)
            S_ATTACK:  step_lim_s = CW'(ATTACK_STEP_CYC - 1);
            S_DECAY:   step_lim_s = CW'(DECAY_STEP_CYC - 1);
            S_RELEASE: step_lim_s = CW'(RELEASE_STEP_CYC - 1);
            default:   step_lim_s = '0;
        endcase
        step_hit_s = (step_q == step_lim_s);
    end

    // Envelope FSM: note events take priority over a coinciding step, note_start over note_end.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        step_d  = '0;
        case (state_q)
            S_IDLE: begin
                env_d = 8'd0;
                if (note_start) begin
                    state_d = S_ATTACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ATTACK: begin
                if (note_start) begin
                    state_d = S_ATTACK;
                end else if (note_end) begin
                    state_d = S_RELEASE;
                end else if (step_hit_s) begin
                    if (env_q >= 8'd254) begin
                        env_d   = 8'd255;
                        state_d = S_DECAY;
                    end else begin
                        env_d = env_q + 8'd1;
                    end
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            S_DECAY: begin
                if (note_start) begin
                    state_d = S_ATTACK;
                end else if (note_end) begin
                    state_d = S_RELEASE;
                end else if (step_hit_s) begin
                    if (env_q <= SUS_P1) begin
                        env_d   = SUS_L;
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = env_q - 8'd1;
                    end
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            S_SUSTAIN: begin
                if (note_start) begin
                    state_d = S_ATTACK;
                end else if (note_end) begin
                    state_d = S_RELEASE;
                end else begin
`ifdef SPK_ENV_TREMOLO_EN
                    env_d = trem_env_s;
`else
                    env_d = SUS_L;
`endif
                end
            end
            S_RELEASE: begin
                if (note_start) begin
                    state_d = S_ATTACK;
                end else if (step_hit_s) begin
                    if (env_q <= 8'd1) begin
                        env_d   = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        env_d = env_q - 8'd1;
                    end
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                env_d   = 8'd0;
            end
        endcase
    end

    // Amplitude scaling and PWM compare feeding the registered speaker output.
    always_comb begin
        vol_p1_s      = {1'b0, volume} + 5'd1;
        prod_s        = {4'd0, env_q} * {7'd0, vol_p1_s};
        amp_s         = prod_s[11:4];
        unused_frac_s = prod_s[3:0];
        pwm_d         = pwm_q + 8'd1;
        speaker_d     = sync_q[1] & (pwm_q < amp_s);
        busy_d        = (state_d != S_IDLE);
    end

    // State, counters, synchronizer and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            env_q     <= 8'd0;
            pwm_q     <= 8'd0;
            sync_q    <= 2'b00;
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            env_q     <= env_d;
            pwm_q     <= pwm_d;
            sync_q    <= {sync_q[0], tone_in};
            speaker_q <= speaker_d;
            busy_q    <= busy_d;
        end
    end

    assign speaker   = speaker_q;
    assign env_level = env_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_speaker_envelope_pwm.sv
// Scoreboard bench for speaker_envelope_pwm with short step periods; expectations are queued by cycle and checked by a monitor.
module tb_speaker_envelope_pwm;

    localparam int K_ENV  = 0;
    localparam int K_BUSY = 1;
    localparam int K_SPK  = 2;
    localparam int K_DUTY = 3;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tone_in;
    logic       note_start;
    logic       note_end;
    logic [3:0] volume;
    logic       speaker;
    logic [7:0] env_level;
    logic       busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit spk_ring [256];

    speaker_envelope_pwm #(
        .ATTACK_STEP_CYC (2),
        .DECAY_STEP_CYC  (2),
        .RELEASE_STEP_CYC(4),
        .SUSTAIN_LEVEL   (160)
`ifdef SPK_ENV_TREMOLO_EN
        ,
        .TREM_STEP_CYC   (2)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tone_in   (tone_in),
        .note_start(note_start),
        .note_end  (note_end),
        .volume    (volume),
        .speaker   (speaker),
        .env_level (env_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs speaker samples and compares every expectation due this cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        int          sum;
        spk_ring[cyc % 256] = (speaker === 1'b1);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: check due at cycle %0d not reached (now %0d)", e.name, e.cyc, cyc);
            end else begin
                case (e.kind)
                    K_ENV:   act = {24'd0, env_level};
                    K_BUSY:  act = {31'd0, busy};
                    K_SPK:   act = {31'd0, speaker};
                    default: begin
                        sum = 0;
                        for (int i = 0; i < 256; i++) sum += int'(spk_ring[i]);
                        act = sum;
                    end
                endcase
                if (act !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.val, cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int c, input int k, input int v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick(1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0, r0, s0, r1, p0, q0, c0;
        rst_n      = 1'b0;
        tone_in    = 1'b0;
        note_start = 1'b0;
        note_end   = 1'b0;
        volume     = 4'd15;

        // Reset held for three edges with the tone toggling.
        for (int i = 1; i <= 3; i++) begin
            expect_at(i, K_SPK,  0, "rst_speaker");
            expect_at(i, K_ENV,  0, "rst_env");
            expect_at(i, K_BUSY, 0, "rst_busy");
        end
        for (int i = 0; i < 3; i++) begin
            tone_in = ~tone_in;
            tick(1);
        end
        rst_n   = 1'b1;
        tone_in = 1'b1;
        expect_at(cyc + 4, K_SPK, 0, "idle_speaker");
        tick(5);

        // Attack, decay, sustain.
        note_start = 1'b1;
        e0 = cyc + 1;
        tick(1);
        note_start = 1'b0;
        expect_at(e0,       K_BUSY, 1,   "start_busy");
        expect_at(e0,       K_ENV,  0,   "start_env");
        expect_at(e0 + 2,   K_ENV,  1,   "attack_first");
        expect_at(e0 + 509, K_ENV,  254, "attack_254");
        expect_at(e0 + 510, K_ENV,  255, "attack_peak");
        expect_at(e0 + 512, K_ENV,  254, "decay_first");
        expect_at(e0 + 698, K_ENV,  161, "decay_161");
        expect_at(e0 + 700, K_ENV,  160, "sustain_reach");

`ifdef SPK_ENV_TREMOLO_EN
        expect_at(e0 + 702, K_ENV,  159, "trem_first");
        expect_at(e0 + 762, K_ENV,  129, "trem_bottom");
        expect_at(e0 + 764, K_ENV,  130, "trem_rise");
        expect_at(e0 + 824, K_ENV,  160, "trem_top");
        expect_at(e0 + 824, K_BUSY, 1,   "trem_busy");
        expect_at(e0 + 826, K_ENV,  159, "trem_again");
        wait_to(e0 + 829);
        note_end = 1'b1;
        r0 = cyc + 1;
        tick(1);
        note_end = 1'b0;
        expect_at(r0,     K_ENV, 158, "trem_release_start");
        expect_at(r0 + 4, K_ENV, 157, "trem_release_step");
        wait_to(r0 + 5);
`else
        expect_at(e0 + 800, K_ENV,  160, "sustain_hold");
        expect_at(e0 + 800, K_BUSY, 1,   "sustain_busy");
        wait_to(e0 + 800);

        // PWM duty over a full 256-cycle window.
        volume = 4'd7;
        c0 = cyc;
        expect_at(c0 + 260, K_DUTY, 80, "duty_vol7");
        wait_to(c0 + 260);
        volume = 4'd0;
        c0 = cyc;
        expect_at(c0 + 260, K_DUTY, 10, "duty_vol0");
        wait_to(c0 + 260);
        volume = 4'd15;
        c0 = cyc;
        expect_at(c0 + 260, K_DUTY, 160, "duty_vol15");
        wait_to(c0 + 260);

        // Full release from sustain.
        note_end = 1'b1;
        r0 = cyc + 1;
        tick(1);
        note_end = 1'b0;
        expect_at(r0,       K_ENV,  160, "release_start");
        expect_at(r0,       K_BUSY, 1,   "release_busy");
        expect_at(r0 + 4,   K_ENV,  159, "release_first");
        expect_at(r0 + 636, K_ENV,  1,   "release_1");
        expect_at(r0 + 639, K_BUSY, 1,   "release_busy_late");
        expect_at(r0 + 640, K_ENV,  0,   "release_zero");
        expect_at(r0 + 640, K_BUSY, 0,   "release_idle");
        wait_to(r0 + 645);
        note_end = 1'b1;
        tick(1);
        note_end = 1'b0;
        expect_at(cyc + 2, K_BUSY, 0, "idle_note_end");
        expect_at(cyc + 2, K_SPK,  0, "idle_spk");
        wait_to(cyc + 3);

        // Same-cycle start and end in sustain: start wins.
        note_start = 1'b1;
        c0 = cyc + 1;
        tick(1);
        note_start = 1'b0;
        expect_at(c0 + 700, K_ENV, 160, "resustain");
        wait_to(c0 + 705);
        note_start = 1'b1;
        note_end   = 1'b1;
        s0 = cyc + 1;
        tick(1);
        note_start = 1'b0;
        note_end   = 1'b0;
        expect_at(s0,     K_BUSY, 1,   "both_busy");
        expect_at(s0 + 1, K_ENV,  160, "both_hold");
        expect_at(s0 + 2, K_ENV,  161, "both_attack");
        expect_at(s0 + 4, K_ENV,  162, "both_attack2");

        // note_end on a step boundary: no step taken that cycle.
        wait_to(s0 + 11);
        note_end = 1'b1;
        r1 = cyc + 1;
        tick(1);
        note_end = 1'b0;
        expect_at(r1,       K_ENV, 165, "end_on_step");
        expect_at(r1 + 3,   K_ENV, 165, "release_wait");
        expect_at(r1 + 4,   K_ENV, 164, "release_dec");
        expect_at(r1 + 260, K_ENV, 100, "release_100");
        wait_to(r1 + 261);
`endif

        // Retrigger from release: continues upward from the current level.
        note_start = 1'b1;
        p0 = cyc + 1;
        tick(1);
        note_start = 1'b0;
        expect_at(p0, K_BUSY, 1, "retrig_busy");
`ifndef SPK_ENV_TREMOLO_EN
        expect_at(p0,     K_ENV, 100, "retrig_no_dip");
        expect_at(p0 + 1, K_ENV, 100, "retrig_hold");
        expect_at(p0 + 2, K_ENV, 101, "retrig_up");
        expect_at(p0 + 4, K_ENV, 102, "retrig_up2");
`endif
        wait_to(p0 + 5);

        // Reset during attack.
        rst_n = 1'b0;
        q0 = cyc + 1;
        tick(1);
        rst_n = 1'b1;
        expect_at(q0,     K_ENV,  0, "midreset_env");
        expect_at(q0,     K_BUSY, 0, "midreset_busy");
        expect_at(q0,     K_SPK,  0, "midreset_spk");
        expect_at(q0 + 3, K_BUSY, 0, "post_reset_idle");
        expect_at(q0 + 3, K_ENV,  0, "post_reset_env");

        for (int i = 0; i < 2000 && sb.size() > 0; i++) tick(1);
        tick(1);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never checked", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
